// File: rtl/dct_pkg.sv
// Shared constants and types for the DCT peripheral Avalon-MM master.
package dct_pkg;

    localparam logic [7:0] ADDR_START = 8'd0;
    localparam logic [7:0] ADDR_DATA  = 8'd1;
    localparam logic [7:0] ADDR_SETQ  = 8'd2;

    localparam int unsigned DEFAULT_NBITS    = 16;
    localparam int unsigned DEFAULT_MAX_SIZE = 256;

    typedef enum logic [2:0] {
        StIdle,
        StSetq,
        StSize,
        StLoad,
        StRead,
        StFin
    } state_e;

endpackage

// File: rtl/dct_rd_timer.sv
// Read-stall watchdog: counts consecutive enabled cycles, flags the TIMEOUT-th one.
module dct_rd_timer #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired = enable && (cnt_q == W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dct_master.sv
// Avalon-MM master that streams one DCT transform through the peripheral.
// Optional read watchdog enabled by defining DCT_MASTER_TIMEOUT_EN.
module dct_master
    import dct_pkg::*;
#(
    parameter int unsigned MAX_SIZE = DEFAULT_MAX_SIZE,
    parameter int unsigned NBITS    = DEFAULT_NBITS,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [8:0]       size,
    input  logic [NBITS-1:0] q_m,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBITS-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] out_data,
    output logic [7:0]       out_index,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [7:0]       avm_address,
    output logic             avm_read,
    output logic             avm_write,
    output logic [NBITS-1:0] avm_writedata,
    input  logic [NBITS-1:0] avm_readdata,
    input  logic             avm_done
);

    state_e           state_q, state_d;
    logic [7:0]       k_q, k_d;
    logic [8:0]       size_q, size_d;
    logic [NBITS-1:0] q_m_q, q_m_d;
    logic [NBITS-1:0] out_data_q, out_data_d;
    logic [7:0]       out_index_q, out_index_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic             fin_err_q, fin_err_d;

    logic size_ok, last_k, drained, rd_accept, timeout_hit;

    assign size_ok   = (size >= 9'd2) && (32'(size) <= MAX_SIZE - 1);
    assign last_k    = ({1'b0, k_q} == size_q - 9'd1);
    assign drained   = !out_valid_q || out_ready;
    assign rd_accept = (state_q == StRead) && avm_done && drained;

`ifdef DCT_MASTER_TIMEOUT_EN
    dct_rd_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_rd_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  ((state_q != StRead) || avm_done),
        .enable ((state_q == StRead) && !avm_done),
        .expired(timeout_hit)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        size_d      = size_q;
        q_m_d       = q_m_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_valid_d = out_valid_q && !out_ready;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        fin_err_d   = fin_err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    size_d    = size;
                    q_m_d     = q_m;
                    busy_d    = 1'b1;
                    fin_err_d = !size_ok;
                    state_d   = size_ok ? StSetq : StFin;
                end
            end
            StSetq: state_d = StSize;
            StSize: begin
                state_d = StLoad;
                k_d     = '0;
            end
            StLoad: begin
                if (in_valid) begin
                    if (last_k) begin
                        state_d = StRead;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + 8'd1;
                    end
                end
            end
            StRead: begin
                if (rd_accept) begin
                    out_data_d  = avm_readdata;
                    out_index_d = k_q;
                    out_valid_d = 1'b1;
                    if (last_k) begin
                        state_d = StFin;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + 8'd1;
                    end
                end else if (timeout_hit) begin
                    state_d   = StFin;
                    fin_err_d = 1'b1;
                end
            end
            StFin: begin
                // Hold completion until the last result has left the output register.
                if (drained) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    error_d = fin_err_q;
                    k_d     = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            k_q         <= '0;
            size_q      <= '0;
            q_m_q       <= '0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            fin_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            size_q      <= size_d;
            q_m_q       <= q_m_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            fin_err_q   <= fin_err_d;
        end
    end

    // Sample writes pass straight through so a LOAD beat costs no extra cycle.
    always_comb begin
        avm_write     = 1'b0;
        avm_address   = '0;
        avm_writedata = '0;
        unique case (state_q)
            StSetq: begin
                avm_write     = 1'b1;
                avm_address   = ADDR_SETQ;
                avm_writedata = q_m_q;
            end
            StSize: begin
                avm_write     = 1'b1;
                avm_address   = ADDR_START;
                avm_writedata = NBITS'(size_q);
            end
            StLoad: begin
                avm_write     = in_valid;
                avm_address   = ADDR_DATA;
                avm_writedata = in_data;
            end
            StRead:  avm_address = k_q;
            default: ;
        endcase
    end

    assign avm_read  = (state_q == StRead);
    assign in_ready  = (state_q == StLoad);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_dct_master.sv
// Scoreboard bench for dct_master with an Avalon responder returning 0x100+address.
module tb_dct_master;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  size = '0;
    logic [15:0] q_m = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [7:0]  out_index;
    logic        busy, done, error;
    logic [7:0]  avm_address;
    logic        avm_read, avm_write;
    logic [15:0] avm_writedata, avm_readdata;
    logic        avm_done;

    always #5 clk = ~clk;

    dct_master #(
        .MAX_SIZE(256),
        .NBITS   (16),
        .TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .size         (size),
        .q_m          (q_m),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_index    (out_index),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .avm_address  (avm_address),
        .avm_read     (avm_read),
        .avm_write    (avm_write),
        .avm_writedata(avm_writedata),
        .avm_readdata (avm_readdata),
        .avm_done     (avm_done)
    );

    int n_checks = 0;
    int n_pass = 0;

    logic [23:0] exp_wr[$];  // {address, writedata}
    logic [23:0] exp_rd[$];  // {data, index}

    // Responder state: stall_len low cycles on stall_addr, or stuck low entirely.
    logic       stuck = 1'b0;
    logic [7:0] stall_addr = 8'hff;
    int         stall_len = 0;
    int         stall_cnt = 0;
    logic       stall_hit = 1'b0;
    logic       stall_clr = 1'b0;
    int         stall_cycles = 0;

    assign avm_readdata = 16'h0100 + {8'h00, avm_address};
    assign avm_done = !stuck &&
        !(avm_read && avm_address == stall_addr && stall_cnt < stall_len);

    logic        rdy_rand = 1'b0;
    logic        expect_bus = 1'b1;
    int          cyc = 0;
    int          done_cnt = 0;
    logic        last_err = 1'b0;
    int          done_cyc = 0;
    int          rd_start_cyc = 0;
    int          last_beat_cyc = 0;
    logic        prev_hold = 1'b0, prev_rd_pend = 1'b0, prev_read = 1'b0;
    logic [23:0] prev_out = '0;
    logic [7:0]  prev_addr = '0;

    task automatic sb_sample();
        logic [23:0] e;
        if (!reset) begin
            prev_hold = 1'b0;
            prev_rd_pend = 1'b0;
            prev_read = 1'b0;
            stall_clr = 1'b1;
            stall_hit = 1'b0;
            return;
        end
        if (avm_read || avm_write) begin
            n_checks++;
            if (!expect_bus || (avm_read && avm_write))
                $display("FAIL bus_activity: read=%b write=%b, required bus allowed=%b and not both",
                         avm_read, avm_write, expect_bus);
            else n_pass++;
        end
        if (avm_write) begin
            n_checks++;
            if (exp_wr.size() == 0) begin
                $display("FAIL avm_write: got addr=%0d data=%h, required no write",
                         avm_address, avm_writedata);
            end else begin
                e = exp_wr.pop_front();
                if ({avm_address, avm_writedata} !== e)
                    $display("FAIL avm_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             avm_address, avm_writedata, e[23:16], e[15:0]);
                else n_pass++;
            end
        end
        if (prev_hold) begin
            n_checks++;
            if (!out_valid || {out_data, out_index} !== prev_out)
                $display("FAIL out_hold: got valid=%b %h/%0d, required valid=1 %h/%0d",
                         out_valid, out_data, out_index, prev_out[23:8], prev_out[7:0]);
            else n_pass++;
        end
        if (prev_rd_pend && avm_read) begin
            n_checks++;
            if (avm_address !== prev_addr)
                $display("FAIL rd_addr_hold: got %0d, required %0d", avm_address, prev_addr);
            else n_pass++;
        end
        if (out_valid && out_ready) begin
            n_checks++;
            last_beat_cyc = cyc;
            if (exp_rd.size() == 0) begin
                $display("FAIL result: got %h/%0d, required no result", out_data, out_index);
            end else begin
                e = exp_rd.pop_front();
                if ({out_data, out_index} !== e)
                    $display("FAIL result: got %h/%0d, required %h/%0d",
                             out_data, out_index, e[23:8], e[7:0]);
                else n_pass++;
            end
        end
        if (avm_read && !prev_read) rd_start_cyc = cyc;
        if (avm_read && !avm_done) stall_cycles++;
        if (done) begin
            done_cnt++;
            last_err = error;
            done_cyc = cyc;
        end
        prev_hold = out_valid && !out_ready;
        prev_out = {out_data, out_index};
        prev_rd_pend = avm_read && !(avm_done && (!out_valid || out_ready));
        prev_addr = avm_address;
        prev_read = avm_read;
        stall_clr = !busy;
        stall_hit = avm_read && avm_address == stall_addr && stall_cnt < stall_len;
    endtask

    // One clock: observe at negedge, then drive at posedge+1.
    task automatic tick();
        @(negedge clk);
        sb_sample();
        @(posedge clk);
        cyc++;
        #1;
        if (stall_clr) stall_cnt = 0;
        else if (stall_hit) stall_cnt++;
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic push_run(input logic [8:0] sz, input logic [15:0] qm);
        exp_wr.push_back({8'd2, qm});
        exp_wr.push_back({8'd0, 7'd0, sz});
        for (int i = 0; i < int'(sz); i++) exp_rd.push_back({16'h0100 + 16'(i), 8'(i)});
    endtask

    task automatic do_start(input logic [8:0] sz, input logic [15:0] qm);
        start = 1'b1;
        size = sz;
        q_m = qm;
        tick();
        start = 1'b0;
    endtask

    task automatic send_samples(input int n, input int gap, input logic [15:0] base);
        int to;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data = base + 16'(i);
            exp_wr.push_back({8'd1, in_data});
            to = 0;
            while (!in_ready && to < 50) begin
                tick();
                to++;
            end
            if (!in_ready) begin
                n_checks++;
                $display("FAIL in_ready: got 0 for 50 cycles, required 1");
            end
            tick();
            in_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic wait_done(input int limit);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < limit) begin
            tick();
            n++;
        end
        if (done_cnt == d0) begin
            n_checks++;
            $display("FAIL wait_done: got no done in %0d cycles, required done", limit);
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, error, in_ready, out_valid, avm_read, avm_write, out_data, out_index,
             avm_address, avm_writedata} !== '0)
            $display("FAIL reset_outputs: got busy=%b done=%b in_ready=%b out_valid=%b rd=%b wr=%b, required all 0",
                     busy, done, in_ready, out_valid, avm_read, avm_write);
        else n_pass++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int d0;
        d0 = done_cnt;
        push_run(9'd4, 16'd0);
        do_start(9'd4, 16'd0);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL basic_busy: got %b, required 1", busy);
        else n_pass++;
        send_samples(4, 0, 16'd7);
        wait_done(100);
        repeat (3) tick();
        n_checks++;
        if (done_cnt != d0 + 1 || last_err !== 1'b0 || exp_wr.size() != 0 || exp_rd.size() != 0)
            $display("FAIL basic_end: got dones=%0d err=%b left wr=%0d rd=%0d, required 1 0 0 0",
                     done_cnt - d0, last_err, exp_wr.size(), exp_rd.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        push_run(9'd6, 16'h0003);
        do_start(9'd6, 16'h0003);
        send_samples(6, 0, 16'h0200);
        wait_done(100);
        n_checks++;
        if (last_beat_cyc - rd_start_cyc != 6 || done_cyc - rd_start_cyc != 7)
            $display("FAIL back_to_back: got last beat +%0d done +%0d, required +6 +7",
                     last_beat_cyc - rd_start_cyc, done_cyc - rd_start_cyc);
        else n_pass++;
        tick();
    endtask

    task automatic test_gapped();
        push_run(9'd3, 16'h0004);
        do_start(9'd3, 16'h0004);
        send_samples(3, 2, 16'h0040);
        wait_done(100);
        tick();
        n_checks++;
        if (exp_wr.size() != 0 || exp_rd.size() != 0 || last_err !== 1'b0)
            $display("FAIL gapped_end: got left wr=%0d rd=%0d err=%b, required 0 0 0",
                     exp_wr.size(), exp_rd.size(), last_err);
        else n_pass++;
    endtask

    task automatic test_stall_backpressure();
        int s0;
        s0 = stall_cycles;
        stall_addr = 8'd1;
        stall_len = 5;
        rdy_rand = 1'b1;
        push_run(9'd3, 16'h0001);
        do_start(9'd3, 16'h0001);
        send_samples(3, 0, 16'd20);
        wait_done(300);
        rdy_rand = 1'b0;
        stall_len = 0;
        tick();
        n_checks++;
        if (stall_cycles - s0 != 5 || exp_rd.size() != 0 || last_err !== 1'b0)
            $display("FAIL stall: got stall cycles=%0d left rd=%0d err=%b, required 5 0 0",
                     stall_cycles - s0, exp_rd.size(), last_err);
        else n_pass++;
    endtask

    task automatic test_bad_size();
        expect_bus = 1'b0;
        do_start(9'd1, 16'h0001);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL bad1_fin: got busy=%b done=%b, required 1 0", busy, done);
        else n_pass++;
        tick();
        n_checks++;
        if (done !== 1'b1 || error !== 1'b1 || busy !== 1'b0)
            $display("FAIL bad1_done: got done=%b error=%b busy=%b, required 1 1 0", done, error, busy);
        else n_pass++;
        tick();
        start = 1'b1;
        size = 9'd256;
        tick();
        size = 9'd4;  // valid request held through FIN must be ignored
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL bad256_fin: got busy=%b done=%b, required 1 0", busy, done);
        else n_pass++;
        tick();
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || error !== 1'b1 || busy !== 1'b0)
            $display("FAIL bad256_done: got done=%b error=%b busy=%b, required 1 1 0", done, error, busy);
        else n_pass++;
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL bad_after: got done=%b busy=%b, required 0 0", done, busy);
        else n_pass++;
        expect_bus = 1'b1;
    endtask

    task automatic test_start_while_busy();
        push_run(9'd2, 16'h0a0a);
        do_start(9'd2, 16'h0a0a);
        start = 1'b1;
        size = 9'd200;
        q_m = 16'h0055;
        tick();
        start = 1'b0;
        send_samples(2, 0, 16'h0030);
        wait_done(100);
        tick();
        n_checks++;
        if (exp_wr.size() != 0 || exp_rd.size() != 0 || busy !== 1'b0)
            $display("FAIL start_busy: got left wr=%0d rd=%0d busy=%b, required 0 0 0",
                     exp_wr.size(), exp_rd.size(), busy);
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        int d0;
        push_run(9'd5, 16'h0003);
        do_start(9'd5, 16'h0003);
        send_samples(2, 0, 16'h0011);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, error, in_ready, out_valid, avm_read, avm_write, out_data, out_index,
             avm_address, avm_writedata} !== '0)
            $display("FAIL midrun_reset: got busy=%b in_ready=%b wr=%b addr=%0d, required all 0",
                     busy, in_ready, avm_write, avm_address);
        else n_pass++;
        exp_wr.delete();
        exp_rd.delete();
        d0 = done_cnt;
        tick();
        tick();
        reset = 1'b1;
        push_run(9'd2, 16'h0007);
        do_start(9'd2, 16'h0007);
        send_samples(2, 0, 16'h0022);
        wait_done(100);
        tick();
        n_checks++;
        if (done_cnt != d0 + 1 || exp_wr.size() != 0 || exp_rd.size() != 0 || last_err !== 1'b0)
            $display("FAIL after_reset_run: got dones=%0d left wr=%0d rd=%0d err=%b, required 1 0 0 0",
                     done_cnt - d0, exp_wr.size(), exp_rd.size(), last_err);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int d0;
        d0 = done_cnt;
        stuck = 1'b1;
        exp_wr.push_back({8'd2, 16'h0001});
        exp_wr.push_back({8'd0, 16'd2});
        do_start(9'd2, 16'h0001);
        send_samples(2, 0, 16'h0050);
`ifdef DCT_MASTER_TIMEOUT_EN
        wait_done(60);
        n_checks++;
        if (last_err !== 1'b1 || done_cyc - rd_start_cyc != 17 || done_cnt != d0 + 1)
            $display("FAIL timeout: got err=%b done at +%0d dones=%0d, required 1 +17 1",
                     last_err, done_cyc - rd_start_cyc, done_cnt - d0);
        else n_pass++;
        stuck = 1'b0;
        tick();
`else
        repeat (40) tick();
        n_checks++;
        if (busy !== 1'b1 || avm_read !== 1'b1 || done_cnt != d0)
            $display("FAIL no_timeout: got busy=%b read=%b dones=%0d, required 1 1 0",
                     busy, avm_read, done_cnt - d0);
        else n_pass++;
        reset = 1'b0;
        stuck = 1'b0;
        tick();
        reset = 1'b1;
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_gapped();
        test_stall_backpressure();
        test_bad_size();
        test_start_while_busy();
        test_reset_midrun();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dct_master.md
DCT_MASTER -- requirements
Module: dct_master

Interface
REQ-001 Parameters: MAX_SIZE, default 256, bound on transform length; NBITS, default 16, sample/result width; TIMEOUT, default 1024, read-stall limit in cycles.
REQ-002 clk  input  1  single clock; all logic on posedge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to run one transform; ignored unless IDLE.
REQ-005 size  input  9  transform length N, sampled on accepted start.
REQ-006 q_m  input  NBITS  Q-format integer bits M, sampled on accepted start.
REQ-007 in_valid / in_ready / in_data  input / output / input  1 / 1 / NBITS  sample stream; beat on valid&&ready.
REQ-008 out_valid / out_ready / out_data / out_index  output / input / output / output  1 / 1 / NBITS / 8  result stream; beat on valid&&ready.
REQ-009 busy  output  1  high from accepted start until done pulse.
REQ-010 done / error  output  1 / 1  one-cycle completion pulse; error qualifies it.
REQ-011 avm_address / avm_read / avm_write / avm_writedata  output  8 / 1 / 1 / NBITS  Avalon-MM master toward the DCT peripheral.
REQ-012 avm_readdata / avm_done  input  NBITS / 1  read data; avm_done low stalls a pending read.

Function
REQ-013 FSM states IDLE, SETQ, SIZE, LOAD, READ, FIN.
REQ-014 IDLE: start with 2<=size<=MAX_SIZE-1 -> SETQ, busy=1; out-of-range size -> FIN with error=1, zero bus activity.
REQ-015 SETQ: exactly one cycle avm_write=1, avm_address=2, avm_writedata=q_m -> SIZE.
REQ-016 SIZE: exactly one cycle avm_write=1, avm_address=0, avm_writedata=size -> LOAD; sample counter k=0.
REQ-017 LOAD: in_ready=1; each beat drives avm_write=1, avm_address=1, avm_writedata=in_data same cycle (combinational pass-through, zero latency); k++; beat with k==N-1 -> READ, k=0.
REQ-018 LOAD with in_valid low: avm_write=0, no state change; gaps of any length permitted.
REQ-019 Writes complete in one cycle; avm_done ignored when avm_read=0.
REQ-020 READ: avm_read=1, avm_address=k held stable until accepted; accepted when avm_done=1 and output register empty or draining (out_ready=1).
REQ-021 On read acceptance: out_data<=avm_readdata, out_index<=k, out_valid<=1 next cycle; k++; back-to-back reads sustain one result per cycle.
REQ-022 out_valid deasserts only after a beat; out_data/out_index stable while out_valid&&!out_ready.
REQ-023 Acceptance of read k==N-1 -> FIN after final result beat consumed.
REQ-024 FIN: done=1 one cycle, busy=0 same cycle -> IDLE; start in FIN ignored.
REQ-025 start while busy: ignored, no effect on sampled size/q_m.
REQ-026 avm_read and avm_write never both high; neither high in IDLE or FIN.

Reset
REQ-027 reset low: state=IDLE, k=0; busy, done, error, in_ready, out_valid, avm_read, avm_write =0; out_data, out_index, avm_address, avm_writedata =0.
REQ-028 Reset mid-transform abandons it with no done pulse; peripheral state not restored (next SIZE write reinitialises it).

Configuration
REQ-029 Macro DCT_MASTER_TIMEOUT_EN defined: in READ, avm_done low for TIMEOUT consecutive cycles -> drop avm_read, FIN with error=1; counter clears on each acceptance.
REQ-030 Macro undefined: no watchdog, READ waits indefinitely; error asserts only for bad size.

Structure
REQ-031 Package dct_pkg: address constants ADDR_START=0, ADDR_DATA=1, ADDR_SETQ=2; state enum type; default NBITS/MAX_SIZE constants.
REQ-032 Sub-module dct_rd_timer (stall counter, clear/enable/expired), instantiated only under DCT_MASTER_TIMEOUT_EN.

Verification (bench BFM responder: readdata=0x100+address, avm_done programmable)
REQ-033 size=4, q_m=0, samples 7,8,9,10 continuous, out_ready=1 -> writes (2,0),(0,4),(1,7),(1,8),(1,9),(1,10); results 0x100..0x103 with indices 0..3; one done, error=0.
REQ-034 size=3, in_valid gapped 1-on/2-off -> exactly 3 data writes, no write in gap cycles, results 0x100..0x102.
REQ-035 avm_done low 5 cycles on address 1, out_ready toggled 50% -> address 1 held, no result lost or duplicated, order 0,1,2.
REQ-036 size=1 and size=256 -> no bus activity, done with error=1 next cycle after FIN entry; busy pulses one cycle.
REQ-037 reset low during LOAD after 2 samples -> all outputs zero immediately; subsequent size=2 run completes correctly.
REQ-038 With DCT_MASTER_TIMEOUT_EN, TIMEOUT=16, avm_done stuck low -> done with error=1 after 16 stall cycles; without macro, busy remains high.
